downscale_sched: RTL and testbench

DOWNSCALE_SCHED -- requirements
Module: downscale_sched

---
 rtl/pixmap_pkg.sv | 35 +++
 rtl/block_avg4.sv | 35 +++
 rtl/downscale_sched.sv | 207 ++++++++++++++++++++
 tb/tb_downscale_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixmap_pkg.sv
// ----------------------------------------------------------------------------
// pixmap_pkg
// Shared definitions for the 2x2 box-filter downscaler.
//   - default source geometry and the derived destination geometry
//   - address widths of the source and destination memories
//   - scheduler state type
// Build option: DOWNSCALE_ROUND_EN (used by block_avg4) selects a rounded
// average. Without it the average is truncated.
// ----------------------------------------------------------------------------
package pixmap_pkg;

    localparam int unsigned SRC_W_DEF  = 320;
    localparam int unsigned SRC_H_DEF  = 240;

    localparam int unsigned DST_W      = SRC_W_DEF / 2;
    localparam int unsigned DST_H      = SRC_H_DEF / 2;
    localparam int unsigned DST_PIXELS = DST_W * DST_H;

    localparam int unsigned SRC_ADDR_W = 17;
    localparam int unsigned DST_ADDR_W = 15;

    // F0..F3 present the four source addresses of a block.
    // F1..F4 capture the four returned pixels (one-cycle read latency).
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_F3,
        ST_F4,
        ST_WR,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/block_avg4.sv
// ----------------------------------------------------------------------------
// block_avg4
// Combinational average of a 2x2 pixel block.
// Ports:
//   p0..p3 : four 8-bit pixels of the block
//   avg    : 8-bit average
// Build option: DOWNSCALE_ROUND_EN defined  -> avg = (sum + 2) >> 2
//               DOWNSCALE_ROUND_EN undefined -> avg = sum >> 2
// The 10-bit sum holds 4 * 255 = 1020, and sum + 2 <= 1022, so neither
// form can overflow.
// ----------------------------------------------------------------------------
module block_avg4
    import pixmap_pkg::*;
(
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    output logic [7:0] avg
);

    logic [9:0] sum;
    logic [9:0] biased;

    always_comb begin
        sum = 10'(p0) + 10'(p1) + 10'(p2) + 10'(p3);
`ifdef DOWNSCALE_ROUND_EN
        biased = sum + 10'd2;
`else
        biased = sum;
`endif
        avg = biased[9:2];
    end

endmodule

// File: rtl/downscale_sched.sv
// ----------------------------------------------------------------------------
// downscale_sched
// Scheduler for a 2x2 box-filter downscale of one frame. It reads four source
// pixels per destination pixel from a synchronous one-cycle-latency memory,
// averages them and writes one destination pixel. The rate is 6 cycles per
// output pixel.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   start      : starts one pass; accepted only in IDLE, whatever enable is
//   enable     : 1 = advance, 0 = freeze (IDLE still accepts start)
//   busy       : pass in progress (F0..WR)
//   done       : one-cycle pulse after the final write
//   src_addr   : registered source read address
//   src_q      : source read data, valid one cycle after src_addr
//   dst_addr   : destination write address (= pix_count)
//   dst_data   : 2x2 block average
//   dst_we     : destination write strobe, only in WR with enable high
//   pix_count  : output pixels written in the current pass
// Build option: DOWNSCALE_ROUND_EN selects the rounded average in block_avg4.
// Timing is the same in both builds.
// ----------------------------------------------------------------------------
module downscale_sched
    import pixmap_pkg::*;
#(
    parameter int unsigned SRC_W = SRC_W_DEF,
    parameter int unsigned SRC_H = SRC_H_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic [SRC_ADDR_W-1:0] src_addr,
    input  logic [7:0]            src_q,
    output logic [DST_ADDR_W-1:0] dst_addr,
    output logic [7:0]            dst_data,
    output logic                  dst_we,
    output logic [DST_ADDR_W-1:0] pix_count
);

    localparam int unsigned ROW_BLKS = SRC_W / 2;
    localparam int unsigned NPIX     = (SRC_W / 2) * (SRC_H / 2);

    localparam logic [DST_ADDR_W-1:0] LAST_PIX = DST_ADDR_W'(NPIX - 1);
    localparam logic [DST_ADDR_W-1:0] LAST_X   = DST_ADDR_W'(ROW_BLKS - 1);

    localparam logic [SRC_ADDR_W-1:0] OFF_R    = SRC_ADDR_W'(1);
    localparam logic [SRC_ADDR_W-1:0] OFF_D    = SRC_ADDR_W'(SRC_W);
    localparam logic [SRC_ADDR_W-1:0] OFF_DR   = SRC_ADDR_W'(SRC_W + 1);
    localparam logic [SRC_ADDR_W-1:0] STEP_BLK = SRC_ADDR_W'(2);
    localparam logic [SRC_ADDR_W-1:0] STEP_ROW = SRC_ADDR_W'(SRC_W + 2);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [SRC_ADDR_W-1:0] base;
    logic [SRC_ADDR_W-1:0] addr_q;
    logic [DST_ADDR_W-1:0] x_cnt;
    logic [DST_ADDR_W-1:0] pix_q;
    logic [7:0]            p0;
    logic [7:0]            p1;
    logic [7:0]            p2;
    logic [7:0]            p3;

    // Read-data skid. During a freeze the memory keeps being read at the
    // held address. That address already points at the next pixel, so src_q
    // loses the value that is still waiting to be captured. The value is
    // saved on the first frozen cycle and used in place of src_q on resume.
    logic                  stall_d;
    logic [7:0]            q_sav;
    logic [7:0]            q_eff;

    logic                  advance;
    logic                  wr_slot;
    logic                  last_pix;
    logic                  row_end;

    assign advance  = enable || (state == ST_IDLE);
    assign last_pix = (pix_q == LAST_PIX);
    assign row_end  = (x_cnt == LAST_X);
    assign q_eff    = stall_d ? q_sav : src_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        wr_slot   = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_F0;
            ST_F0:   state_nxt = ST_F1;
            ST_F1:   state_nxt = ST_F2;
            ST_F2:   state_nxt = ST_F3;
            ST_F3:   state_nxt = ST_F4;
            ST_F4:   state_nxt = ST_WR;
            ST_WR: begin
                wr_slot   = 1'b1;
                state_nxt = last_pix ? ST_DONE : ST_F0;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!advance) begin
            state_nxt = state;
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    // ------------------------------------------------------------------
    // Datapath
    // src_addr is registered. It is loaded on the edge that enters each
    // fetch state, so it shows B / B+1 / B+W / B+W+1 during F0..F3.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base   <= '0;
            addr_q <= '0;
            x_cnt  <= '0;
            pix_q  <= '0;
            p0     <= '0;
            p1     <= '0;
            p2     <= '0;
            p3     <= '0;
        end else if (advance) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        base   <= '0;
                        addr_q <= '0;
                        x_cnt  <= '0;
                        pix_q  <= '0;
                    end
                end
                ST_F0: addr_q <= base + OFF_R;
                ST_F1: begin
                    p0     <= q_eff;
                    addr_q <= base + OFF_D;
                end
                ST_F2: begin
                    p1     <= q_eff;
                    addr_q <= base + OFF_DR;
                end
                ST_F3: p2 <= q_eff;
                ST_F4: p3 <= q_eff;
                ST_WR: begin
                    pix_q <= pix_q + 1'b1;
                    if (row_end) begin
                        // Skip the second source row of this block row.
                        x_cnt  <= '0;
                        base   <= base + STEP_ROW;
                        addr_q <= base + STEP_ROW;
                    end else begin
                        x_cnt  <= x_cnt + 1'b1;
                        base   <= base + STEP_BLK;
                        addr_q <= base + STEP_BLK;
                    end
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_d <= 1'b0;
            q_sav   <= '0;
        end else begin
            stall_d <= (state != ST_IDLE) && !enable;
            if (!enable && !stall_d) begin
                q_sav <= src_q;
            end
        end
    end

    block_avg4 u_avg (
        .p0  (p0),
        .p1  (p1),
        .p2  (p2),
        .p3  (p3),
        .avg (dst_data)
    );

    assign src_addr  = addr_q;
    assign pix_count = pix_q;
    assign dst_addr  = pix_q;
    assign dst_we    = wr_slot && enable;

endmodule

// File: tb/tb_downscale_sched.sv
// ----------------------------------------------------------------------------
// tb_downscale_sched
// Self-checking bench for downscale_sched. It uses a reduced 40x20 source
// frame (20x10 = 200 output pixels) to keep passes short. The expected block
// averages and read addresses come from raster arithmetic on the bench's own
// source memory.
// Cycle numbering for latency: cycle 1 is the cycle in which start is
// sampled, so done is expected in cycle 6*NP + 2.
// ----------------------------------------------------------------------------
module tb_downscale_sched;

    localparam int SW    = 40;
    localparam int SH    = 20;
    localparam int DW    = SW / 2;
    localparam int DH    = SH / 2;
    localparam int NP    = DW * DH;
    localparam int MEMSZ = SW * SH;
    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        enable;
    logic        busy;
    logic        done;
    logic [16:0] src_addr;
    logic [7:0]  src_q;
    logic [14:0] dst_addr;
    logic [7:0]  dst_data;
    logic        dst_we;
    logic [14:0] pix_count;

    downscale_sched #(.SRC_W(SW), .SRC_H(SH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .src_addr  (src_addr),
        .src_q     (src_q),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_we    (dst_we),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    // Source memory with one-cycle synchronous read.
    logic [7:0] mem [MEMSZ];
    always @(posedge clk) begin
        if (int'(src_addr) < MEMSZ) src_q <= mem[src_addr];
        else                        src_q <= 8'h00;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int top_left(input int k);
        return (2 * (k / DW)) * SW + 2 * (k % DW);
    endfunction

    function automatic logic [7:0] ref_pix(input int k);
        int tl;
        int s;
        tl = top_left(k);
        s  = int'(mem[tl]) + int'(mem[tl + 1]) + int'(mem[tl + SW]) + int'(mem[tl + SW + 1]);
`ifdef DOWNSCALE_ROUND_EN
        return 8'((s + 2) / 4);
`else
        return 8'(s / 4);
`endif
    endfunction

    function automatic logic [71:0] ref_reads(input int k);
        int tl;
        tl = top_left(k);
        return {4'h0, 17'(tl), 17'(tl + 1), 17'(tl + SW), 17'(tl + SW + 1)};
    endfunction

    // ------------------------------------------------------------------
    // Write monitor: order, data, and the four distinct reads per block
    // ------------------------------------------------------------------
    int          exp_idx   = 0;
    int          wr_count  = 0;
    int          wr5_count = 0;
    bit          trace_on  = 1'b0;
    logic [16:0] last_addr = '0;
    logic [16:0] rd_q[$];

    always @(negedge clk) begin
        logic [71:0] got;
        if (rst && start && !busy && !done) begin
            exp_idx = 0;
            rd_q.delete();
        end
        if (src_addr != last_addr) begin
            rd_q.push_back(src_addr);
            last_addr = src_addr;
        end
        if (dst_we) begin
            wr_count++;
            if (dst_addr == 15'd5) wr5_count++;
            chk("wr_addr", 72'(dst_addr), 72'(exp_idx));
            chk("wr_data", 72'(dst_data), 72'(ref_pix(exp_idx)));
            if (trace_on && exp_idx == 0) begin
`ifdef DOWNSCALE_ROUND_EN
                chk("first_blk", 72'(dst_data), 72'd3);
`else
                chk("first_blk", 72'(dst_data), 72'd2);
`endif
            end
            if (trace_on && exp_idx == 7) chk("sat_blk", 72'(dst_data), 72'd255);
            if (trace_on && exp_idx > 0) begin
                got = '1;
                if (rd_q.size() == 4) got = {4'h0, rd_q[0], rd_q[1], rd_q[2], rd_q[3]};
                chk("rd_trace", got, ref_reads(exp_idx));
                if (exp_idx == DW - 1)
                    chk("trace_row_end", got, {4'h0, 17'd38, 17'd39, 17'd78, 17'd79});
                if (exp_idx == DW)
                    chk("trace_row_next", got, {4'h0, 17'd80, 17'd81, 17'd120, 17'd121});
                if (exp_idx == NP - 1)
                    chk("trace_last", got, {4'h0, 17'd758, 17'd759, 17'd798, 17'd799});
            end
            rd_q.delete();
            exp_idx++;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(inout int cyc, input bit rnd_stall);
        while (!done && cyc < LIMIT) begin
            step();
            cyc++;
            if (rnd_stall) begin
                enable = ($urandom_range(7) != 0);
                if (cyc == 40) start = 1'b1;
                else           start = 1'b0;
            end
        end
        start  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  72'(busy),      72'd0);
        chk({tag, "_done"},  72'(done),      72'd0);
        chk({tag, "_we"},    72'(dst_we),    72'd0);
        chk({tag, "_saddr"}, 72'(src_addr),  72'd0);
        chk({tag, "_daddr"}, 72'(dst_addr),  72'd0);
        chk({tag, "_data"},  72'(dst_data),  72'd0);
        chk({tag, "_pix"},   72'(pix_count), 72'd0);
    endtask

    initial begin
        int cyc;
        int w0;

        rst    = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h10;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b1;
        step();

        // Flat 0x10 frame, no stalls: latency, count, done pulse.
        do_start();
        chk("busy_after_start", 72'(busy), 72'd1);
        cyc = 0;
        run_to_done(cyc, 1'b0);
        chk("done_latency", 72'(cyc + 2), 72'(6 * NP + 2));
        chk("flat_writes", 72'(wr_count), 72'(NP));
        chk("pix_final", 72'(pix_count), 72'(NP));
        chk("done_busy", 72'(busy), 72'd0);
        step();
        chk("done_pulse", 72'(done), 72'd0);
        chk("idle_busy", 72'(busy), 72'd0);
        repeat (3) step();
        chk("pix_hold", 72'(pix_count), 72'(NP));

        // Random frame with fixed corner cases, random freezes and an
        // ignored mid-pass start.
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom_range(255));
        mem[0] = 8'd1;  mem[1] = 8'd2;  mem[SW] = 8'd3;  mem[SW + 1] = 8'd4;
        mem[14] = 8'd255; mem[15] = 8'd255; mem[SW + 14] = 8'd255; mem[SW + 15] = 8'd255;
        trace_on = 1'b1;
        w0 = wr_count;
        do_start();
        cyc = 0;
        run_to_done(cyc, 1'b1);
        chk("rand_done_seen", 72'(done), 72'd1);
        chk("rand_writes", 72'(wr_count - w0), 72'(NP));
        trace_on = 1'b0;
        repeat (3) step();

        // Freeze 10 cycles during the write of pixel 5.
        w0 = wr_count;
        wr5_count = 0;
        do_start();
        cyc = 0;
        while (!(dst_we && dst_addr == 15'd5) && cyc < LIMIT) begin
            step();
            cyc++;
        end
        enable = 1'b0;
        repeat (10) begin
            step();
            cyc++;
        end
        enable = 1'b1;
        run_to_done(cyc, 1'b0);
        chk("stall_latency", 72'(cyc + 2), 72'(6 * NP + 2 + 10));
        chk("stall_wr5_once", 72'(wr5_count), 72'd1);
        chk("stall_writes", 72'(wr_count - w0), 72'(NP));
        repeat (3) step();

        // Reset in the middle of a pass, then restart.
        do_start();
        cyc = 0;
        while (pix_count != 15'd100 && cyc < LIMIT) begin
            step();
            cyc++;
        end
        chk("pre_reset_pix", 72'(pix_count), 72'd100);
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        w0 = wr_count;
        step();
        chk_zero("rst_edge");
        repeat (5) step();
        rst = 1'b1;
        repeat (6) step();
        chk("rst_no_writes", 72'(wr_count), 72'(w0));
        chk("rst_stays_idle", 72'(busy), 72'd0);
        do_start();
        cyc = 0;
        while (wr_count == w0 && cyc < LIMIT) begin
            step();
            cyc++;
        end
        chk("restart_first_write", 72'(wr_count - w0), 72'd1);
        cyc = 0;
        run_to_done(cyc, 1'b0);
        chk("restart_writes", 72'(wr_count - w0), 72'(NP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
